hamming_secded_decoder: RTL and testbench
=========================================

// Module: hamming_secded_decoder
// PURPOSE
//  Memory-walking SECDED decoder. Reads NUM_WORDS 16-bit Hamming(16,11) codewords from data memory and
//  checks each one. Corrects single-bit errors and flags double-bit errors.
//  Writes each decoded 11-bit message plus 2-bit status back to data memory.
//  Sits beside dm1 as a hardware accelerator and shares dm1's byte-wide port.
//  Codeword layout: {d11..d5,p8,d4,d3,d2,p4,d1,p2,p1,p0}. Bit k (k=1..15) is Hamming position k; p0 is overall parity.
// PARAMETERS
//  SRC_BASE   30  byte address of codeword 0 (low byte at SRC_BASE+2i, high byte at SRC_BASE+2i+1)
//  DST_BASE   0   byte address of result 0 (low byte at DST_BASE+2i, high byte at DST_BASE+2i+1)
//  NUM_WORDS  15  codewords per run, 1..127
// PORTS
//  clk          in   1  rising-edge clock
//  reset        in   1  asynchronous, active-high
//  start        in   1  1-cycle run request; honoured only in IDLE or DONE
//  mem_addr     out  8  dm1 byte address
//  mem_rd_data  in   8  dm1 read data; combinational w.r.t. mem_addr, sampled at clk edge
//  mem_wr_en    out  1  dm1 write strobe for this cycle
//  mem_wr_data  out  8  dm1 write data
//  done         out  1  high in DONE state
// BEHAVIOUR
//  Reset values: state=IDLE, index i=0, mem_addr=0, mem_wr_en=0, mem_wr_data=0, done=0, all holding regs=0.
//  FSM: IDLE -start-> RD_LO -> RD_HI -> DEC -> WR_LO -> WR_HI.
//   From WR_HI: if i<NUM_WORDS-1, then i++ and go to RD_LO; otherwise go to DONE.
//   From DONE: start clears i and goes to RD_LO.
//  RD_LO: mem_addr=SRC_BASE+2i; capture cw[7:0]. RD_HI: mem_addr=SRC_BASE+2i+1; capture cw[15:8].
//  DEC: register syndrome s=XOR of k over set bits cw[k], k=1..15 (4 bits), and P=^cw[15:0].
//   s==0,P==0: F=2'b00, data taken as-is.
//   P==1: F=2'b01 single error. Flip cw[s]; s==0 means p0 flipped and the data is unchanged.
//   s!=0,P==0: F=2'b10 double error. Data taken uncorrected from the raw codeword.
//  WR_LO: mem_addr=DST_BASE+2i, mem_wr_en=1, mem_wr_data={d8..d1}.
//  WR_HI: mem_addr=DST_BASE+2i+1, mem_wr_en=1, mem_wr_data={F,3'b000,d11,d10,d9}.
//  mem_wr_en is high only in WR_LO and WR_HI. Address arithmetic is 8-bit and wraps modulo 256.
//  Timing: 5 cycles per word. done rises 5*NUM_WORDS cycles after the start cycle.
//   done stays high until the cycle after an accepted start.
//  start while busy (RD_LO..WR_HI): ignored, the current run is not disturbed.
//  reset mid-run: immediate return to IDLE. Writes already made stay in memory. No write occurs in the reset cycle.
// CONFIGURATION
//  HAMMING_DEC_STATS_EN defined: adds outputs n_corrected[7:0] and n_double[7:0].
//   Both clear on reset and on accepted start. Each increments in DEC for F=01 / F=10, saturating at 255.
//  Macro undefined: these ports and counters do not exist. Core behaviour is identical either way.
// STRUCTURE
//  hamming_pkg: state enum dec_state_t; flag constants FLAG_OK=2'b00, FLAG_SEC=2'b01, FLAG_DED=2'b10;
//   codeword bit-position constants; function extract_data(cw)->[11:1].
//  Sub-module secded_dec16 (combinational): cw[15:0] -> data[11:1], flag[1:0].
//   It is instantiated once. The FSM registers its outputs in DEC.
// TESTING
//  1 cw 0xFFFF at mem[31:30], NUM_WORDS=1 -> mem[1]=0x07, mem[0]=0xFF; done 5 cycles after start.
//  2 cw 0xFFF7 (bit3 = d1 flipped) -> mem[1]=0x47, mem[0]=0xFF.
//    cw 0xFFFE (p0 flipped) -> mem[1]=0x47, mem[0]=0xFF.
//  3 cw 0xFFF3 (bits 2,3 flipped) -> mem[1]=0x87, mem[0]=0xFE (uncorrected).
//    cw 0x8000 -> mem[1]=0x40, mem[0]=0x00.
//  4 Full run, NUM_WORDS=15, random encoded data with 0/1/2 random flips per word:
//    all 30 result bytes match the reference model; done at cycle 75; start pulses mid-run are ignored.
//  5 Assert reset during WR_LO of word 7 -> done=0 and mem_wr_en=0 immediately, state IDLE.
//    A new start rewrites all 15 results correctly.
//  6 (STATS_EN) a run with 4 single-error and 3 double-error words -> n_corrected=4, n_double=3.
//    The next start clears both to 0.

Source files
------------

// File: rtl/hamming_pkg.sv
// hamming_pkg: shared types, constants and helper functions for the
// Hamming(16,11) SECDED decoder.
//   dec_state_t    : decoder FSM states
//   FLAG_*         : 2-bit status written with every decoded word
//   POS_*          : codeword bit positions of the parity bits
//   calc_syndrome  : XOR of the positions of all set bits 1..15
//   calc_parity    : overall parity over the full 16-bit codeword
//   extract_data   : pulls d11..d1 out of the codeword layout
package hamming_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RD_LO = 3'd1,
    ST_RD_HI = 3'd2,
    ST_DEC   = 3'd3,
    ST_WR_LO = 3'd4,
    ST_WR_HI = 3'd5,
    ST_DONE  = 3'd6
  } dec_state_t;

  localparam logic [1:0] FLAG_OK  = 2'b00;
  localparam logic [1:0] FLAG_SEC = 2'b01;
  localparam logic [1:0] FLAG_DED = 2'b10;

  // Parity bit positions; every other position 1..15 carries data.
  localparam int unsigned POS_P0 = 0;
  localparam int unsigned POS_P1 = 1;
  localparam int unsigned POS_P2 = 2;
  localparam int unsigned POS_P4 = 4;
  localparam int unsigned POS_P8 = 8;

  function automatic logic [3:0] calc_syndrome(input logic [15:0] cw);
    logic [3:0] syn;
    syn = 4'd0;
    for (int k = 1; k < 16; k++) begin
      if (cw[k]) begin
        syn = syn ^ 4'(k);
      end
    end
    return syn;
  endfunction

  function automatic logic calc_parity(input logic [15:0] cw);
    return ^cw;
  endfunction

  // Layout {d11..d5,p8,d4,d3,d2,p4,d1,p2,p1,p0}
  function automatic logic [11:1] extract_data(input logic [15:0] cw);
    return {cw[15:9], cw[7:5], cw[3]};
  endfunction

endpackage

// File: rtl/secded_dec16.sv
// secded_dec16: purely combinational SECDED check of one 16-bit codeword.
//   cw_i   [15:0] : raw codeword
//   data_o [11:1] : decoded message (corrected for single errors,
//                   raw for double errors)
//   flag_o [1:0]  : FLAG_OK / FLAG_SEC / FLAG_DED
module secded_dec16
  import hamming_pkg::*;
(
  input  logic [15:0] cw_i,
  output logic [11:1] data_o,
  output logic [1:0]  flag_o
);

  logic [3:0]  syn_s;
  logic        par_s;
  logic [15:0] fixed_s;

  // Syndrome/parity evaluation and single-bit correction
  always_comb begin
    syn_s   = calc_syndrome(cw_i);
    par_s   = calc_parity(cw_i);
    // Syndrome 0 with odd parity flips p0 only, so data is untouched.
    fixed_s = cw_i ^ (16'd1 << syn_s);
    if (par_s) begin
      flag_o = FLAG_SEC;
      data_o = extract_data(fixed_s);
    end else if (syn_s != 4'd0) begin
      flag_o = FLAG_DED;
      data_o = extract_data(cw_i);
    end else begin
      flag_o = FLAG_OK;
      data_o = extract_data(cw_i);
    end
  end

endmodule

// File: rtl/hamming_secded_decoder.sv
// hamming_secded_decoder: memory-walking SECDED decoder sharing a byte-wide
// data-memory port. Reads NUM_WORDS codewords starting at SRC_BASE, decodes
// each and writes {data, flag} as two bytes starting at DST_BASE.
//   clk, reset (async, active-high), start (1-cycle run request)
//   mem_addr/mem_rd_data/mem_wr_en/mem_wr_data : byte memory port
//   done : high while in DONE
// Optional: define HAMMING_DEC_STATS_EN to add saturating counters
//   n_corrected[7:0] and n_double[7:0].
module hamming_secded_decoder
  import hamming_pkg::*;
#(
  parameter int unsigned SRC_BASE  = 30,
  parameter int unsigned DST_BASE  = 0,
  parameter int unsigned NUM_WORDS = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic [7:0] mem_addr,
  input  logic [7:0] mem_rd_data,
  output logic       mem_wr_en,
  output logic [7:0] mem_wr_data,
`ifdef HAMMING_DEC_STATS_EN
  output logic [7:0] n_corrected,
  output logic [7:0] n_double,
`endif
  output logic       done
);

  localparam logic [7:0] SRC_B    = 8'(SRC_BASE);
  localparam logic [7:0] DST_B    = 8'(DST_BASE);
  localparam logic [6:0] LAST_IDX = 7'(NUM_WORDS - 1);

  dec_state_t  state_q, state_d;
  logic [6:0]  idx_q, idx_d;
  logic [15:0] cw_q;
  logic [11:1] data_q;
  logic [1:0]  flag_q;
  logic [7:0]  mem_addr_q, mem_addr_d;
  logic        wr_en_q, wr_en_d;
  logic [7:0]  wr_data_q, wr_data_d;
  logic        done_q, done_d;
  logic [11:1] dec_data_s;
  logic [1:0]  dec_flag_s;
  logic        start_ok_s;

  secded_dec16 u_dec (
    .cw_i   (cw_q),
    .data_o (dec_data_s),
    .flag_o (dec_flag_s)
  );

  assign start_ok_s = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));

  // State, index and registered port outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      idx_q      <= 7'd0;
      mem_addr_q <= 8'd0;
      wr_en_q    <= 1'b0;
      wr_data_q  <= 8'd0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      mem_addr_q <= mem_addr_d;
      wr_en_q    <= wr_en_d;
      wr_data_q  <= wr_data_d;
      done_q     <= done_d;
    end
  end

  // Next-state and word-index logic
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d = ST_RD_LO;
          idx_d   = 7'd0;
        end else begin
          state_d = state_q;
        end
      end
      ST_RD_LO: state_d = ST_RD_HI;
      ST_RD_HI: state_d = ST_DEC;
      ST_DEC:   state_d = ST_WR_LO;
      ST_WR_LO: state_d = ST_WR_HI;
      ST_WR_HI: begin
        if (idx_q < LAST_IDX) begin
          state_d = ST_RD_LO;
          idx_d   = idx_q + 7'd1;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        idx_d   = 7'd0;
      end
    endcase
  end

  // Output values for the upcoming state, registered so they are valid
  // for the whole cycle spent in that state. Entering WR_LO, the decoder
  // output is still live from cw_q, so it is used directly.
  always_comb begin
    mem_addr_d = 8'd0;
    wr_en_d    = 1'b0;
    wr_data_d  = 8'd0;
    done_d     = 1'b0;
    case (state_d)
      ST_RD_LO: mem_addr_d = SRC_B + {idx_d, 1'b0};
      ST_RD_HI: mem_addr_d = SRC_B + {idx_d, 1'b0} + 8'd1;
      ST_WR_LO: begin
        mem_addr_d = DST_B + {idx_d, 1'b0};
        wr_en_d    = 1'b1;
        wr_data_d  = dec_data_s[8:1];
      end
      ST_WR_HI: begin
        mem_addr_d = DST_B + {idx_d, 1'b0} + 8'd1;
        wr_en_d    = 1'b1;
        wr_data_d  = {flag_q, 3'b000, data_q[11:9]};
      end
      ST_DONE: done_d = 1'b1;
      default: done_d = 1'b0;
    endcase
  end

  // Codeword capture and decoded-result holding registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cw_q   <= 16'd0;
      data_q <= 11'd0;
      flag_q <= FLAG_OK;
    end else begin
      case (state_q)
        ST_RD_LO: cw_q[7:0]  <= mem_rd_data;
        ST_RD_HI: cw_q[15:8] <= mem_rd_data;
        ST_DEC: begin
          data_q <= dec_data_s;
          flag_q <= dec_flag_s;
        end
        default: cw_q <= cw_q;
      endcase
    end
  end

`ifdef HAMMING_DEC_STATS_EN
  logic [7:0] n_corr_q, n_dbl_q;

  // Saturating error statistics, cleared by every accepted start
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      n_corr_q <= 8'd0;
      n_dbl_q  <= 8'd0;
    end else if (start_ok_s) begin
      n_corr_q <= 8'd0;
      n_dbl_q  <= 8'd0;
    end else if (state_q == ST_DEC) begin
      if ((dec_flag_s == FLAG_SEC) && (n_corr_q != 8'hFF)) begin
        n_corr_q <= n_corr_q + 8'd1;
      end else if ((dec_flag_s == FLAG_DED) && (n_dbl_q != 8'hFF)) begin
        n_dbl_q <= n_dbl_q + 8'd1;
      end else begin
        n_corr_q <= n_corr_q;
      end
    end else begin
      n_corr_q <= n_corr_q;
    end
  end

  assign n_corrected = n_corr_q;
  assign n_double    = n_dbl_q;
`else
  logic unused_start_ok_s;
  assign unused_start_ok_s = start_ok_s;
`endif

  assign mem_addr    = mem_addr_q;
  assign mem_wr_en   = wr_en_q;
  assign mem_wr_data = wr_data_q;
  assign done        = done_q;

endmodule

// File: tb/tb_hamming_secded_decoder.sv
module tb_hamming_secded_decoder;

  localparam int NW  = 15;
  localparam int SRC = 30;
  localparam int DST = 0;

  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] data;
  } wr_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] mem_addr;
  logic [7:0] mem_rd_data;
  logic       mem_wr_en;
  logic [7:0] mem_wr_data;
  logic       done;
`ifdef HAMMING_DEC_STATS_EN
  logic [7:0] n_corrected;
  logic [7:0] n_double;
`endif

  logic [7:0] src_img [256];
  logic [7:0] dut_mem [256];
  logic [7:0] exp_mem [2*NW];
  wr_t        exp_q [$];
  int         n_cmp = 0;
  int         n_bad = 0;

  logic [15:0] dir_cw [5] = '{16'hFFFF, 16'hFFF7, 16'hFFFE, 16'hFFF3, 16'h8000};
  logic [7:0]  dir_lo [5] = '{8'hFF, 8'hFF, 8'hFF, 8'hFE, 8'h00};
  logic [7:0]  dir_hi [5] = '{8'h07, 8'h47, 8'h47, 8'h87, 8'h40};

  hamming_secded_decoder dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .mem_addr    (mem_addr),
    .mem_rd_data (mem_rd_data),
    .mem_wr_en   (mem_wr_en),
    .mem_wr_data (mem_wr_data),
`ifdef HAMMING_DEC_STATS_EN
    .n_corrected (n_corrected),
    .n_double    (n_double),
`endif
    .done        (done)
  );

  always #5 clk = ~clk;

  assign mem_rd_data = src_img[mem_addr];

  always @(posedge clk) begin
    if (mem_wr_en) dut_mem[mem_addr] <= mem_wr_data;
  end

  // Scoreboard monitor: every DUT write is matched against the next expected write
  always @(negedge clk) begin
    wr_t e;
    if (!reset && mem_wr_en) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_write addr=%02h data=%02h (no write expected)", mem_addr, mem_wr_data);
      end else begin
        e = exp_q.pop_front();
        if (mem_addr !== e.addr || mem_wr_data !== e.data) begin
          n_bad++;
          $display("FAIL write got addr=%02h data=%02h expected addr=%02h data=%02h",
                   mem_addr, mem_wr_data, e.addr, e.data);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s got=%0h expected=%0h", name, got, want);
    end
  endtask

  // Reference encoder: data fills non-power-of-two positions in order,
  // parity bit 2^b covers positions with bit b set, p0 makes total parity even.
  function automatic logic [15:0] encode(input logic [10:0] d);
    logic [15:0] cw;
    logic        p;
    int          j;
    cw = 16'h0000;
    j  = 0;
    for (int k = 1; k < 16; k++) begin
      if ((k & (k - 1)) != 0) begin
        cw[k] = d[j];
        j++;
      end
    end
    for (int b = 0; b < 4; b++) begin
      p = 1'b0;
      for (int k = 1; k < 16; k++) begin
        if (((k >> b) & 1) == 1) p = p ^ cw[k];
      end
      cw[1 << b] = p;
    end
    cw[0] = ^cw[15:1];
    return cw;
  endfunction

  function automatic logic [10:0] raw_data(input logic [15:0] cw);
    logic [10:0] d;
    int          j;
    d = 11'd0;
    j = 0;
    for (int k = 1; k < 16; k++) begin
      if ((k & (k - 1)) != 0) begin
        d[j] = cw[k];
        j++;
      end
    end
    return d;
  endfunction

  // mode 0: five directed words then random 0/1/2 flips
  // mode 1: words 0-3 single flip, 4-6 double flip, rest clean
  // mode 2: all random 0/1/2 flips
  task automatic prep_run(input int mode);
    logic [10:0] d, exp_d;
    logic [15:0] cw;
    logic [7:0]  lo, hi;
    logic [1:0]  f;
    int          nf, b1, b2;
    exp_q.delete();
    for (int i = 0; i < NW; i++) begin
      if (mode == 0 && i < 5) begin
        cw = dir_cw[i];
        lo = dir_lo[i];
        hi = dir_hi[i];
      end else begin
        d  = 11'($urandom);
        cw = encode(d);
        if (mode == 1) nf = (i < 4) ? 1 : ((i < 7) ? 2 : 0);
        else nf = int'($urandom_range(0, 2));
        b1 = int'($urandom_range(0, 15));
        b2 = (b1 + int'($urandom_range(1, 15))) % 16;
        if (nf >= 1) cw[b1] = ~cw[b1];
        if (nf == 2) cw[b2] = ~cw[b2];
        if (nf == 2) begin
          f     = 2'b10;
          exp_d = raw_data(cw);
        end else begin
          f     = (nf == 1) ? 2'b01 : 2'b00;
          exp_d = d;
        end
        lo = exp_d[7:0];
        hi = {f, 3'b000, exp_d[10:8]};
      end
      src_img[SRC + 2*i]     = cw[7:0];
      src_img[SRC + 2*i + 1] = cw[15:8];
      exp_q.push_back('{addr: 8'(DST + 2*i),     data: lo});
      exp_q.push_back('{addr: 8'(DST + 2*i + 1), data: hi});
      exp_mem[2*i]     = lo;
      exp_mem[2*i + 1] = hi;
    end
  endtask

  // Issue start, optionally pulse start mid-run, and measure done latency
  task automatic run_to_done(input bit pulses);
    int cnt;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
`ifdef HAMMING_DEC_STATS_EN
    check("stats_clear_corr", 32'(n_corrected), 32'd0);
    check("stats_clear_dbl", 32'(n_double), 32'd0);
`endif
    cnt = 0;
    while (!done && cnt < 300) begin
      @(posedge clk);
      #1;
      cnt++;
      start = (pulses && (cnt == 20 || cnt == 41)) ? 1'b1 : 1'b0;
    end
    start = 1'b0;
    check("done_latency", 32'(cnt), 32'(5*NW));
    @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    for (int k = 0; k < 2*NW; k++) check("mem_result", 32'(dut_mem[DST + k]), 32'(exp_mem[k]));
  endtask

  initial begin
    int         cnt;
    int         busy;
    logic [7:0] old14;
    reset = 1'b1;
    start = 1'b0;
    for (int k = 0; k < 256; k++) begin
      src_img[k] = 8'h00;
      dut_mem[k] = 8'h00;
    end
    repeat (3) @(posedge clk);
    #1;
    check("rst_done", 32'(done), 32'd0);
    check("rst_wr_en", 32'(mem_wr_en), 32'd0);
    check("rst_addr", 32'(mem_addr), 32'd0);
    check("rst_wr_data", 32'(mem_wr_data), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Directed vectors plus random words, with ignored mid-run starts
    prep_run(0);
    run_to_done(1'b1);
    check("done_holds", 32'(done), 32'd1);

    // Known single/double error mix
    prep_run(1);
    run_to_done(1'b0);
`ifdef HAMMING_DEC_STATS_EN
    check("stats_corr", 32'(n_corrected), 32'd4);
    check("stats_dbl", 32'(n_double), 32'd3);
`endif

    // Reset during WR_LO of word 7
    prep_run(2);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
`ifdef HAMMING_DEC_STATS_EN
    check("stats_clear_corr", 32'(n_corrected), 32'd0);
    check("stats_clear_dbl", 32'(n_double), 32'd0);
`endif
    cnt = 0;
    while (!(mem_wr_en && mem_addr == 8'(DST + 14)) && cnt < 300) begin
      @(negedge clk);
      cnt++;
    end
    check("reach_word7", 32'(cnt < 300), 32'd1);
    old14 = dut_mem[DST + 14];
    #2;
    reset = 1'b1;
    #1;
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_wr_en", 32'(mem_wr_en), 32'd0);
    check("midrst_addr", 32'(mem_addr), 32'd0);
    @(posedge clk);
    #1;
    check("midrst_no_write", 32'(dut_mem[DST + 14]), 32'(old14));
    exp_q.delete();
    @(negedge clk);
    reset = 1'b0;
    busy = 0;
    repeat (10) begin
      @(negedge clk);
      if (mem_wr_en || done) busy++;
    end
    check("idle_after_reset", 32'(busy), 32'd0);

    // Fresh run after the aborted one rewrites every result
    prep_run(2);
    run_to_done(1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
